// File: rtl/uart_frame_arbiter_if.sv
// Handshake bundle between the two frame sources, the arbiter and the UART
// frame transmitter. The arbiter takes the master side.
interface uart_frame_arbiter_if #(
    parameter int FRAME_W = 188
);
    logic               i_Req0;
    logic [FRAME_W-1:0] i_Data0;
    logic               i_Req1;
    logic [FRAME_W-1:0] i_Data1;
    logic               o_Ack0;
    logic               o_Ack1;
    logic               o_Done0;
    logic               o_Done1;
    logic               o_Tx_DV;
    logic [FRAME_W-1:0] o_Tx_Frame;
    logic               i_Tx_Active;
    logic               i_Tx_Done;
    logic               o_Busy;
    logic               o_Owner;

    modport master (
        input  i_Req0, i_Data0, i_Req1, i_Data1, i_Tx_Active, i_Tx_Done,
        output o_Ack0, o_Ack1, o_Done0, o_Done1, o_Tx_DV, o_Tx_Frame,
               o_Busy, o_Owner
    );

    modport slave (
        output i_Req0, i_Data0, i_Req1, i_Data1, i_Tx_Active, i_Tx_Done,
        input  o_Ack0, o_Ack1, o_Done0, o_Done1, o_Tx_DV, o_Tx_Frame,
               o_Busy, o_Owner
    );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one frame transmitter between two frame
// sources. Launches a frame with a one-cycle strobe, counts per-byte done
// edges to find the end of frame, then holds off until the line has been
// idle for GAP_CLKS consecutive cycles.
module uart_frame_arbiter #(
    parameter int FRAME_W         = 188,
    parameter int BYTES_PER_FRAME = 24,
    parameter int GAP_CLKS        = 217
) (
    input logic                 i_Clock,
    input logic                 i_Reset,
    uart_frame_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [15:0] GAP_LAST  = 16'(GAP_CLKS - 1);
    localparam logic [4:0]  BYTE_LAST = 5'(BYTES_PER_FRAME - 1);

    state_t             state_reg;
    logic [15:0]        gap_cnt_reg;
    logic [4:0]         byte_cnt_reg;
    logic               tx_done_prev_reg;
    logic               last_reg;
    logic               owner_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               tx_dv_reg;
    logic [1:0]         ack_reg;
    logic [1:0]         done_reg;
    logic               busy_reg;

    logic               winner;
    logic               done_rise;

    // Pick the requester to grant: a lone request wins outright, a tie goes
    // to whoever was not served last.
    always_comb begin
        winner = bus.i_Req1;
        if (bus.i_Req0 && bus.i_Req1) begin
            winner = ~last_reg;
        end
    end

    assign done_rise = bus.i_Tx_Done & ~tx_done_prev_reg;

    // Arbitration FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg        <= GAP;
            gap_cnt_reg      <= '0;
            byte_cnt_reg     <= '0;
            tx_done_prev_reg <= 1'b0;
            last_reg         <= 1'b1;
            owner_reg        <= 1'b0;
            frame_reg        <= '0;
            tx_dv_reg        <= 1'b0;
            ack_reg          <= '0;
            done_reg         <= '0;
            busy_reg         <= 1'b1;
        end else begin
            tx_dv_reg        <= 1'b0;
            ack_reg          <= '0;
            done_reg         <= '0;
            tx_done_prev_reg <= bus.i_Tx_Done;
            case (state_reg)
                GAP: begin
                    // Any activity restarts the idle guard, so the short
                    // inter-byte low windows of a stray frame never satisfy it.
                    if (bus.i_Tx_Active) begin
                        gap_cnt_reg <= '0;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                IDLE: begin
                    if (bus.i_Req0 || bus.i_Req1) begin
                        frame_reg       <= winner ? bus.i_Data1 : bus.i_Data0;
                        owner_reg       <= winner;
                        last_reg        <= winner;
                        tx_dv_reg       <= 1'b1;
                        ack_reg[winner] <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= LOAD;
                    end
                end
                LOAD: begin
                    byte_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // Only the rising edge of done counts, however long it stays high.
                    if (done_rise) begin
                        byte_cnt_reg <= byte_cnt_reg + 5'd1;
                        if (byte_cnt_reg == BYTE_LAST) begin
                            done_reg[owner_reg] <= 1'b1;
                            gap_cnt_reg         <= '0;
                            state_reg           <= GAP;
                        end
                    end
                end
                default: begin
                    state_reg <= GAP;
                end
            endcase
        end
    end

    assign bus.o_Tx_DV    = tx_dv_reg;
    assign bus.o_Tx_Frame = frame_reg;
    assign bus.o_Ack0     = ack_reg[0];
    assign bus.o_Ack1     = ack_reg[1];
    assign bus.o_Done0    = done_reg[0];
    assign bus.o_Done1    = done_reg[1];
    assign bus.o_Busy     = busy_reg;
    assign bus.o_Owner    = owner_reg;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter with a small byte-level transmitter model.
module tb_uart_frame_arbiter;

    localparam int FRAME_W = 188;
    localparam int BYTES   = 24;
    localparam int GAP     = 8;
    localparam logic [FRAME_W-1:0] PAT0 = {4'h9, {22{8'h3C}}, 8'hA5};
    localparam logic [FRAME_W-1:0] PAT1 = {4'h6, {23{8'h5A}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done0 = 0;
    int   n_done1 = 0;
    int   n_ack1 = 0;
    int   n_dv = 0;
    int   done_cyc = 0;
    int   rise_cyc = 0;

    uart_frame_arbiter_if #(.FRAME_W(FRAME_W)) ifc ();

    uart_frame_arbiter #(
        .FRAME_W(FRAME_W),
        .BYTES_PER_FRAME(BYTES),
        .GAP_CLKS(GAP)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (ifc.o_Done0) begin
            n_done0  <= n_done0 + 1;
            done_cyc <= cyc;
        end
        if (ifc.o_Done1) begin
            n_done1  <= n_done1 + 1;
            done_cyc <= cyc;
        end
        if (ifc.o_Ack1)  n_ack1 <= n_ack1 + 1;
        if (ifc.o_Tx_DV) n_dv   <= n_dv + 1;
    end

    task automatic chk(input string tag, input logic [FRAME_W-1:0] obs,
                       input logic [FRAME_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int budget, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.o_Tx_DV === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    // Each byte: active for 3 cycles, then done high for dw cycles, then one low cycle.
    task automatic run_frame(input int dw, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            ifc.i_Tx_Active = 1'b1;
            repeat (3) @(negedge clk);
            ifc.i_Tx_Done = 1'b1;
            rise_cyc = cyc;
            repeat (dw) @(negedge clk);
            ifc.i_Tx_Done   = 1'b0;
            ifc.i_Tx_Active = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t;
        int d0;
        int d1;
        int a1;
        int dv0;
        int lo;
        int exp_o;

        ifc.i_Req0 = 1'b0;
        ifc.i_Req1 = 1'b0;
        ifc.i_Data0 = '0;
        ifc.i_Data1 = '0;
        ifc.i_Tx_Active = 1'b0;
        ifc.i_Tx_Done = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chki("rst_busy",  32'(ifc.o_Busy), 1);
        chki("rst_dv",    32'(ifc.o_Tx_DV), 0);
        chki("rst_ack0",  32'(ifc.o_Ack0), 0);
        chki("rst_ack1",  32'(ifc.o_Ack1), 0);
        chki("rst_done0", 32'(ifc.o_Done0), 0);
        chki("rst_done1", 32'(ifc.o_Done1), 0);
        chki("rst_owner", 32'(ifc.o_Owner), 0);
        chk("rst_frame", ifc.o_Tx_Frame, '0);

        // Idle guard after reset: IDLE exactly GAP cycles after release
        rst = 1'b0;
        repeat (GAP - 1) @(negedge clk);
        chki("gap_busy_hold", 32'(ifc.o_Busy), 1);
        @(negedge clk);
        chki("gap_busy_fall", 32'(ifc.o_Busy), 0);

        // Single request from requester 0
        ifc.i_Data0 = PAT0;
        ifc.i_Req0  = 1'b1;
        wait_dv(6, ok, t);
        chki("t2_dv_seen", 32'(ok), 1);
        chki("t2_ack0",  32'(ifc.o_Ack0), 1);
        chki("t2_ack1",  32'(ifc.o_Ack1), 0);
        chki("t2_owner", 32'(ifc.o_Owner), 0);
        chk("t2_frame", ifc.o_Tx_Frame, PAT0);
        $display("frame launch owner=0 cycle=%0d", t);
        ifc.i_Req0 = 1'b0;
        @(negedge clk);
        chki("t2_dv_single",   32'(ifc.o_Tx_DV), 0);
        chki("t2_ack0_single", 32'(ifc.o_Ack0), 0);
        d0 = n_done0;
        run_frame(2, 23);
        chki("t2_no_early_done", n_done0 - d0, 0);
        chki("t2_busy_wait", 32'(ifc.o_Busy), 1);
        run_frame(2, 1);
        chki("t2_one_done", n_done0 - d0, 1);
        chki("t2_done_timing", done_cyc, rise_cyc + 1);
        chk("t2_frame_hold", ifc.o_Tx_Frame, PAT0);

        // Both requesting from reset: order 0,1,0,1 with gap enforced
        ifc.i_Data0 = PAT0;
        ifc.i_Data1 = PAT1;
        ifc.i_Req0  = 1'b1;
        ifc.i_Req1  = 1'b1;
        do_reset();
        d0 = n_done0;
        d1 = n_done1;
        for (int k = 0; k < 4; k++) begin
            exp_o = k % 2;
            wait_dv(60, ok, t);
            chki($sformatf("t3_dv_seen%0d", k), 32'(ok), 1);
            chki($sformatf("t3_owner%0d", k), 32'(ifc.o_Owner), exp_o);
            chki($sformatf("t3_ack0_%0d", k), 32'(ifc.o_Ack0), 32'(exp_o == 0));
            chki($sformatf("t3_ack1_%0d", k), 32'(ifc.o_Ack1), 32'(exp_o == 1));
            chk($sformatf("t3_frame%0d", k), ifc.o_Tx_Frame, (exp_o == 1) ? PAT1 : PAT0);
            if (k > 0) begin
                chki($sformatf("t3_gap%0d", k), 32'((t - done_cyc) >= GAP + 1), 1);
            end
            $display("frame launch owner=%0d cycle=%0d", exp_o, t);
            run_frame(2, 24);
        end
        ifc.i_Req0 = 1'b0;
        ifc.i_Req1 = 1'b0;
        chki("t3_done0_count", n_done0 - d0, 2);
        chki("t3_done1_count", n_done1 - d1, 2);

        // Long done pulses, requester 1 alone
        ifc.i_Data1 = PAT0;
        ifc.i_Req1  = 1'b1;
        wait_dv(60, ok, t);
        chki("t4_dv_seen", 32'(ok), 1);
        chki("t4_owner", 32'(ifc.o_Owner), 1);
        chki("t4_ack1",  32'(ifc.o_Ack1), 1);
        chk("t4_frame", ifc.o_Tx_Frame, PAT0);
        $display("frame launch owner=1 cycle=%0d", t);
        ifc.i_Req1 = 1'b0;
        d1 = n_done1;
        run_frame(5, 23);
        chki("t4_no_early_done", n_done1 - d1, 0);
        run_frame(5, 1);
        chki("t4_one_done", n_done1 - d1, 1);
        chki("t4_done_timing", done_cyc, rise_cyc + 1);

        // Reset at byte 10 with the line still toggling
        ifc.i_Data0 = PAT1;
        ifc.i_Req0  = 1'b1;
        wait_dv(60, ok, t);
        chki("t5_dv_seen", 32'(ok), 1);
        chki("t5_ack0", 32'(ifc.o_Ack0), 1);
        $display("frame launch owner=0 cycle=%0d (to be aborted)", t);
        run_frame(2, 10);
        d0 = n_done0;
        ifc.i_Tx_Active = 1'b1;
        rst = 1'b1;
        #1;
        chki("t5_rst_busy",  32'(ifc.o_Busy), 1);
        chki("t5_rst_owner", 32'(ifc.o_Owner), 0);
        chk("t5_rst_frame", ifc.o_Tx_Frame, '0);
        @(negedge clk);
        rst = 1'b0;
        dv0 = n_dv;
        for (int p = 0; p < 3; p++) begin
            ifc.i_Tx_Active = 1'b1;
            repeat (40) @(negedge clk);
            ifc.i_Tx_Active = 1'b0;
            repeat (2) @(negedge clk);
        end
        ifc.i_Tx_Active = 1'b1;
        repeat (3) @(negedge clk);
        chki("t5_no_grant_toggle", n_dv - dv0, 0);
        chki("t5_busy_toggle", 32'(ifc.o_Busy), 1);
        ifc.i_Tx_Active = 1'b0;
        lo = cyc;
        wait_dv(40, ok, t);
        chki("t5_dv_seen_after", 32'(ok), 1);
        chki("t5_guard_cycle", t, lo + GAP + 1);
        chki("t5_no_done_abort", n_done0 - d0, 0);
        chk("t5_frame", ifc.o_Tx_Frame, PAT1);
        $display("frame launch owner=0 cycle=%0d (re-request)", t);
        ifc.i_Req0 = 1'b0;

        // Requester 1 pulses a request during WAIT and withdraws it
        d0 = n_done0;
        run_frame(2, 5);
        a1  = n_ack1;
        dv0 = n_dv;
        ifc.i_Req1 = 1'b1;
        @(negedge clk);
        ifc.i_Req1 = 1'b0;
        run_frame(2, 19);
        chki("t6_done0", n_done0 - d0, 1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.o_Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chki("t6_idle_reached", 32'(ok), 1);
        repeat (10) @(negedge clk);
        chki("t6_busy_stays_low", 32'(ifc.o_Busy), 0);
        chki("t6_no_ack1", n_ack1 - a1, 0);
        chki("t6_no_dv", n_dv - dv0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Shares the single 188-bit frame transmitter (24 bytes per frame, 8N1) between two frame sources: the game-board dump (requester 0) and the debug/score dump (requester 1). It grants requesters round-robin, launches one frame with a single-cycle data-valid strobe, and counts per-byte done pulses to detect end of frame. It then enforces an idle guard on the line before the next grant. It sits between the Tetris AI core and the UART transmitter.

## Interface
- FRAME_W, 188: frame payload width in bits.
- BYTES_PER_FRAME, 24: number of transmitter done pulses that make up one frame.
- GAP_CLKS, 217: number of consecutive cycles with i_Tx_Active low required before a grant. Legal range 4..65535.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req0  in  1  level request from requester 0; held until o_Ack0.
- i_Data0  in  FRAME_W  requester 0 payload; valid while i_Req0 is high.
- i_Req1  in  1  level request from requester 1; held until o_Ack1.
- i_Data1  in  FRAME_W  requester 1 payload.
- o_Ack0 / o_Ack1  out  1  one-cycle pulse; payload captured and request may drop.
- o_Done0 / o_Done1  out  1  one-cycle pulse; the owner's frame has fully left the line.
- o_Tx_DV  out  1  one-cycle launch strobe to the transmitter.
- o_Tx_Frame  out  FRAME_W  registered payload; held stable from launch until the next grant.
- i_Tx_Active  in  1  transmitter active flag; drops briefly between bytes.
- i_Tx_Done  in  1  transmitter done flag; high about 2 cycles per byte.
- o_Busy  out  1  high whenever the state is not IDLE.
- o_Owner  out  1  index of the current or last granted requester.

## Operation
- States: GAP, IDLE, LOAD, WAIT.
- GAP: a 16-bit counter increments while i_Tx_Active is 0 and clears to 0 when i_Tx_Active is 1.
  - Reaching GAP_CLKS-1 → IDLE.
  - The short low windows between bytes (≤3 cycles) never satisfy the guard, so a frame left running across a reset is waited out.
- IDLE: with any request asserted → LOAD. Winner selection:
  - Only one request → that requester.
  - Both requests → the requester not equal to r_Last.
  - On grant: o_Tx_Frame ← winner's data, o_Owner ← winner, r_Last ← winner.
- LOAD (exactly one cycle): o_Tx_DV=1 and o_AckN=1 for the owner; byte counter ← 0 → WAIT.
- WAIT: rising-edge detect on i_Tx_Done, comparing against a registered previous value.
  - Each edge increments a 5-bit byte counter.
  - The edge that brings the count to BYTES_PER_FRAME: o_DoneN=1 for one cycle, go to GAP.
  - Further i_Tx_Done high cycles within the same pulse are not counted.
- A request dropped before its ack is legal: it is simply not granted.
- A request raised during LOAD, WAIT or GAP is served at the next IDLE.
- Request level and data are sampled only in IDLE.

## Timing
- Reset values:
  - State = GAP, with the gap counter at 0.
  - r_Last = 1, so requester 0 wins the first tie.
  - o_Tx_DV, o_Ack0/1, o_Done0/1 = 0; o_Tx_Frame = 0; o_Owner = 0; o_Busy = 1.
  - Byte counter = 0; done-edge register = 0.
- Reset asserted mid-frame: all outputs take reset values immediately. No o_Done pulse is issued for the aborted frame. The requester has already been acked and must re-request.
- Grant latency:
  - Request high in IDLE at edge N → o_Ack and o_Tx_DV high during cycle N+1 → WAIT at N+2.
  - The transmitter samples o_Tx_DV on the falling edge inside cycle N+1.
- End of frame: o_Done is high the cycle after the 24th i_Tx_Done rising edge is registered.
- Back-to-back frames: the gap from o_Done to the next o_Tx_DV is at least GAP_CLKS+1 cycles.
- o_Busy is 0 only in IDLE. Minimum frame-to-frame occupancy is BYTES_PER_FRAME byte times plus GAP_CLKS.

## Test plan
- Reset, i_Tx_Active=0 → o_Busy falls after exactly GAP_CLKS cycles. With GAP_CLKS=8, IDLE is reached 8 cycles after reset deasserts.
- Single request: i_Req0=1, i_Data0=188'h…A5 → o_Ack0 and o_Tx_DV high the same single cycle, o_Tx_Frame=188'h…A5. Model 24 done pulses (each 2 cycles wide) → exactly one o_Done0 after the 24th, none earlier.
- Simultaneous i_Req0=i_Req1=1 from reset, both held:
  - Grant order is 0, 1, 0, 1; each grant follows the previous o_Done by ≥GAP_CLKS+1 cycles.
  - o_Owner matches each ack.
- Long done pulse: i_Tx_Done held 5 cycles per byte → counter still advances once per byte, and o_Done fires after 24 bytes.
- Reset at byte 10 while i_Tx_Active toggles (high for 40 cycles, low for 2):
  - No grant until i_Tx_Active has stayed low for GAP_CLKS cycles.
  - No o_Done0 for the aborted frame.
- Request withdrawn: i_Req1 pulsed high for one cycle during WAIT, then low → no o_Ack1 after the next IDLE, and o_Busy stays 0.
